// File: rtl/jam1_pkg.sv
// Shared JAM-1 sequencer definitions: state encoding, NOP opcode and the
// per-state output decode used by the pipeline sequencer.
package jam1_pkg;

    typedef enum logic [2:0] {
        S_FILL   = 3'd0,
        S_RUN    = 3'd1,
        S_FLUSH  = 3'd2,
        S_DRAIN  = 3'd3,
        S_GRANT  = 3'd4,
        S_RESUME = 3'd5
    } state_t;

    localparam logic [7:0] NOP_OPCODE = 8'h00;

    typedef struct packed {
        logic pipe_advance;
        logic inject_nop;
        logic pc_inc;
        logic bus_grant;
        logic running;
    } seq_out_t;

    // Moore output pattern for each state; FetchSuppress is OR-ed in by the top.
    function automatic seq_out_t decode_state(input state_t s);
        seq_out_t o;
        o = '0;
        case (s)
            S_FILL: begin
                o.pipe_advance = 1'b1;
                o.inject_nop   = 1'b1;
            end
            S_RUN: begin
                o.pipe_advance = 1'b1;
                o.pc_inc       = 1'b1;
                o.running      = 1'b1;
            end
            S_FLUSH: begin
                o.pipe_advance = 1'b1;
                o.inject_nop   = 1'b1;
                o.pc_inc       = 1'b1;
            end
            S_GRANT: begin
                o.bus_grant    = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/pipe_sequencer.sv
// JAM-1 pipeline sequencer: stage-register advance, NOP injection, PC gating
// and CPU/external-master bus arbitration.
module pipe_sequencer
    import jam1_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH   = 4,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic BusRequest,
    input  logic MemBusy,
    input  logic FetchSuppress,
    input  logic BranchTaken,
    output logic PipeAdvance,
    output logic InjectNop,
    output logic PCInc,
    output logic BusGrant,
    output logic Running
);

    localparam logic [CNT_W-1:0] CNT_FILL  = CNT_W'(PIPE_DEPTH);
    localparam logic [CNT_W-1:0] CNT_FLUSH = CNT_W'(FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_dec;
    logic             cnt_last;
    seq_out_t         out_q;
    seq_out_t         out_next;

    // Saturating decrement; a count of 0 or 1 both end the phase.
    assign cnt_dec  = (cnt == '0) ? '0 : cnt - CNT_ONE;
    assign cnt_last = (cnt <= CNT_ONE);

    // State, counter and output registers; outputs are pre-decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FILL;
            cnt   <= CNT_FILL;
            out_q <= decode_state(S_FILL);
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            out_q <= out_next;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_FILL: begin
                if (cnt_last) begin
                    state_next = S_RUN;
                end else begin
                    cnt_next = cnt_dec;
                end
            end
            S_RUN: begin
                if (BranchTaken) begin
                    state_next = S_FLUSH;
                    cnt_next   = CNT_FLUSH;
                end else if (BusRequest) begin
                    state_next = S_DRAIN;
                end
            end
            S_FLUSH: begin
                if (BranchTaken) begin
                    cnt_next = CNT_FLUSH;
                end else if (cnt_last) begin
                    state_next = BusRequest ? S_DRAIN : S_RUN;
                end else begin
                    cnt_next = cnt_dec;
                end
            end
            S_DRAIN: begin
                // A request withdrawn before the grant goes straight back to running.
                if (!BusRequest) begin
                    state_next = S_RUN;
                end else if (!MemBusy) begin
                    state_next = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!BusRequest) begin
                    state_next = S_RESUME;
                end
            end
            S_RESUME: begin
                state_next = S_RUN;
            end
            default: begin
                state_next = S_FILL;
                cnt_next   = CNT_FILL;
            end
        endcase
        out_next = decode_state(state_next);
    end

    assign PipeAdvance = out_q.pipe_advance;
    assign PCInc       = out_q.pc_inc;
    assign BusGrant    = out_q.bus_grant;
    assign Running     = out_q.running;
    // Operand bytes are still fetched but must not reach decode as opcodes.
    assign InjectNop   = out_q.inject_nop | (out_q.running & FetchSuppress);

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer with a queue of expected output vectors.
module tb_pipe_sequencer;

    logic clk;
    logic rst_n;
    logic BusRequest;
    logic MemBusy;
    logic FetchSuppress;
    logic BranchTaken;
    logic PipeAdvance;
    logic InjectNop;
    logic PCInc;
    logic BusGrant;
    logic Running;

    int errors = 0;
    int checks = 0;

    logic [4:0] exp_q[$];
    string      tag_q[$];
    logic [4:0] obs;

    // Vector order: {PipeAdvance, InjectNop, PCInc, BusGrant, Running}
    localparam logic [4:0] V_FILL   = 5'b11000;
    localparam logic [4:0] V_RUN    = 5'b10101;
    localparam logic [4:0] V_RUN_FS = 5'b11101;
    localparam logic [4:0] V_FLUSH  = 5'b11100;
    localparam logic [4:0] V_HOLD   = 5'b00000;
    localparam logic [4:0] V_GRANT  = 5'b00010;

    assign obs = {PipeAdvance, InjectNop, PCInc, BusGrant, Running};

    pipe_sequencer #(
        .PIPE_DEPTH  (4),
        .FLUSH_CYCLES(2),
        .CNT_W       (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .BusRequest   (BusRequest),
        .MemBusy      (MemBusy),
        .FetchSuppress(FetchSuppress),
        .BranchTaken  (BranchTaken),
        .PipeAdvance  (PipeAdvance),
        .InjectNop    (InjectNop),
        .PCInc        (PCInc),
        .BusGrant     (BusGrant),
        .Running      (Running)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_out();
        logic [4:0] e;
        string      t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", t, obs, e);
        end
    endtask

    // One cycle: drive inputs at the falling edge, queue the expectation, then compare.
    task automatic step(input string tag, input logic rst, input logic br, input logic mb,
                        input logic fs, input logic bt, input logic [4:0] exp_v);
        @(negedge clk);
        rst_n         = rst;
        BusRequest    = br;
        MemBusy       = mb;
        FetchSuppress = fs;
        BranchTaken   = bt;
        exp_q.push_back(exp_v);
        tag_q.push_back(tag);
        #1;
        check_out();
    endtask

    // Safety invariants sampled every cycle.
    always @(posedge clk) begin
        #2;
        checks++;
        assert (!(BusGrant && PipeAdvance)) else begin
            errors++;
            $error("FAIL inv_grant_adv: observed=%b%b expected=not both 1", BusGrant, PipeAdvance);
        end
        checks++;
        assert (!(BusGrant && MemBusy)) else begin
            errors++;
            $error("FAIL inv_grant_busy: observed=%b%b expected=not both 1", BusGrant, MemBusy);
        end
    end

    initial begin
        rst_n = 1'b0; BusRequest = 1'b0; MemBusy = 1'b0;
        FetchSuppress = 1'b0; BranchTaken = 1'b0;

        // Reset held three cycles, then exactly four fill cycles.
        for (int i = 0; i < 3; i++) step("reset_hold", 0, 0, 0, 0, 0, V_FILL);
        for (int i = 0; i < 4; i++) step("fill", 1, 0, 0, 0, 0, V_FILL);
        step("run_after_fill", 1, 0, 0, 0, 0, V_RUN);
        step("run_idle", 1, 0, 0, 0, 0, V_RUN);

        // Bus arbitration with MemBusy outstanding for two drain cycles.
        step("bus_req_run", 1, 1, 1, 0, 0, V_RUN);
        step("drain_busy1", 1, 1, 1, 0, 0, V_HOLD);
        step("drain_busy2", 1, 1, 1, 0, 0, V_HOLD);
        step("drain_free", 1, 1, 0, 0, 0, V_HOLD);
        step("grant", 1, 1, 0, 0, 0, V_GRANT);
        step("grant_req_drop", 1, 0, 0, 0, 0, V_GRANT);
        step("resume", 1, 0, 0, 0, 0, V_HOLD);
        step("run_after_resume", 1, 0, 0, 0, 0, V_RUN);

        // Branch flush: two NOP slots with PC still incrementing.
        step("branch_run", 1, 0, 0, 0, 1, V_RUN);
        step("flush1", 1, 0, 0, 0, 0, V_FLUSH);
        step("flush2", 1, 0, 0, 0, 0, V_FLUSH);
        step("run_after_flush", 1, 0, 0, 0, 0, V_RUN);

        // Branch and bus request together: flush first, then drain and grant.
        step("collide_run", 1, 1, 0, 0, 1, V_RUN);
        step("collide_flush1", 1, 1, 0, 0, 0, V_FLUSH);
        step("collide_flush2", 1, 1, 0, 0, 0, V_FLUSH);
        step("collide_drain", 1, 1, 0, 0, 0, V_HOLD);
        step("collide_grant", 1, 1, 0, 0, 0, V_GRANT);
        step("collide_grant_drop", 1, 0, 0, 0, 0, V_GRANT);
        step("collide_resume", 1, 0, 0, 0, 0, V_HOLD);
        step("collide_run_after", 1, 0, 0, 0, 0, V_RUN);

        // FetchSuppress forces a NOP for that cycle only.
        step("fetch_suppress", 1, 0, 0, 1, 0, V_RUN_FS);
        step("fetch_normal", 1, 0, 0, 0, 0, V_RUN);

        // Request withdrawn during drain: back to run, no grant.
        step("abort_req", 1, 1, 1, 0, 0, V_RUN);
        step("abort_drain", 1, 0, 1, 0, 0, V_HOLD);
        step("abort_run", 1, 0, 0, 0, 0, V_RUN);

        // Branch inside the flush reloads the shadow count.
        step("reload_branch", 1, 0, 0, 0, 1, V_RUN);
        step("reload_flush_bt", 1, 0, 0, 0, 1, V_FLUSH);
        step("reload_flush1", 1, 0, 0, 0, 0, V_FLUSH);
        step("reload_flush2", 1, 0, 0, 0, 0, V_FLUSH);
        step("reload_run", 1, 0, 0, 0, 0, V_RUN);

        // Branch while draining is ignored.
        step("drain_bt_req", 1, 1, 1, 0, 0, V_RUN);
        step("drain_bt_ignored", 1, 1, 1, 0, 1, V_HOLD);
        step("drain_bt_still", 1, 1, 0, 0, 0, V_HOLD);
        step("drain_bt_grant", 1, 1, 0, 0, 0, V_GRANT);

        // Asynchronous reset mid-grant drops BusGrant without a clock edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.push_back(V_FILL);
        tag_q.push_back("async_reset_grant");
        #1;
        check_out();
        BusRequest = 1'b0;
        step("reset_hold2", 0, 0, 0, 0, 0, V_FILL);
        for (int i = 0; i < 4; i++) step("refill", 1, 0, 0, 0, 0, V_FILL);
        step("run_after_refill", 1, 0, 0, 0, 0, V_RUN);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
